// File: rtl/register_file_pkg.sv
// Shared processor constants: default datapath widths and the hardwired-zero register index.
package register_file_pkg;

    localparam int REG_DATA_W = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ZERO_REG   = 0;

endpackage

// File: rtl/register_file_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an outstanding write and reports
// whether each decode source must wait.
module reg_scoreboard
    import register_file_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issueValid,
    input  logic [ADDR_W-1:0] issueReg,
    input  logic              clearValid,
    input  logic [ADDR_W-1:0] clearReg,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic              busy1,
    output logic              busy2
);

    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busyNext;

    // The set is applied after the clear so a same-index issue overrides the retiring write.
    always_comb begin
        busyNext = busy;
        if (clearValid) begin
            busyNext[clearReg] = 1'b0;
        end
        if (issueValid && (issueReg != ZERO_IDX)) begin
            busyNext[issueReg] = 1'b1;
        end
        busyNext[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busyNext;
        end
    end

    // A writeback landing this cycle releases its reader immediately.
    always_comb begin
        busy1 = busy[readReg1] && !(clearValid && (clearReg == readReg1));
        busy2 = busy[readReg2] && !(clearValid && (clearReg == readReg2));
    end

endmodule

// File: rtl/register_file.sv
// Two-read, one-write register file with hardwired r0, same-cycle write-through
// bypass and a busy scoreboard for pending destinations.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regWriteW,
    input  logic [ADDR_W-1:0] writeRegW,
    input  logic [DATA_W-1:0] resultW,
    input  logic [ADDR_W-1:0] readReg1D,
    input  logic [ADDR_W-1:0] readReg2D,
    output logic [DATA_W-1:0] readData1D,
    output logic [DATA_W-1:0] readData2D,
    input  logic              issueValidD,
    input  logic [ADDR_W-1:0] issueRegD,
    output logic              busy1D,
    output logic              busy2D
);

    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs [NREG];
    logic              writeEn;

    assign writeEn = regWriteW && (writeRegW != ZERO_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (writeEn) begin
            regs[writeRegW] <= resultW;
        end
    end

    // Reads stay live during reset; bypass lets decode see the value being written back.
    always_comb begin
        if (readReg1D == ZERO_IDX) begin
            readData1D = '0;
        end else if (writeEn && (writeRegW == readReg1D)) begin
            readData1D = resultW;
        end else begin
            readData1D = regs[readReg1D];
        end
    end

    always_comb begin
        if (readReg2D == ZERO_IDX) begin
            readData2D = '0;
        end else if (writeEn && (writeRegW == readReg2D)) begin
            readData2D = resultW;
        end else begin
            readData2D = regs[readReg2D];
        end
    end

    reg_scoreboard #(
        .ADDR_W(ADDR_W)
    ) scoreboard (
        .clk       (clk),
        .rst       (rst),
        .issueValid(issueValidD),
        .issueReg  (issueRegD),
        .clearValid(regWriteW),
        .clearReg  (writeRegW),
        .readReg1  (readReg1D),
        .readReg2  (readReg2D),
        .busy1     (busy1D),
        .busy2     (busy2D)
    );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed vector table, hand-written
// corner sequences, then randomized traffic against an array-based model.
module tb_register_file;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          regWriteW;
    logic [AW-1:0] writeRegW;
    logic [DW-1:0] resultW;
    logic [AW-1:0] readReg1D;
    logic [AW-1:0] readReg2D;
    logic [DW-1:0] readData1D;
    logic [DW-1:0] readData2D;
    logic          issueValidD;
    logic [AW-1:0] issueRegD;
    logic          busy1D;
    logic          busy2D;

    typedef struct {
        logic          rst;
        logic          we;
        logic [AW-1:0] wr;
        logic [DW-1:0] wd;
        logic          iv;
        logic [AW-1:0] ir;
        logic [AW-1:0] r1;
        logic [AW-1:0] r2;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
        logic          eb1;
        logic          eb2;
    } vec_t;

    vec_t tbl[$];

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] mRegs [NR];
    bit            mBusy [NR];

    always #5 clk = ~clk;

    register_file dut (
        .clk        (clk),
        .rst        (rst),
        .regWriteW  (regWriteW),
        .writeRegW  (writeRegW),
        .resultW    (resultW),
        .readReg1D  (readReg1D),
        .readReg2D  (readReg2D),
        .readData1D (readData1D),
        .readData2D (readData2D),
        .issueValidD(issueValidD),
        .issueRegD  (issueRegD),
        .busy1D     (busy1D),
        .busy2D     (busy2D)
    );

    task automatic addVec(input logic r, input logic we, input logic [AW-1:0] wr,
                          input logic [DW-1:0] wd, input logic iv, input logic [AW-1:0] ir,
                          input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                          input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                          input logic eb1, input logic eb2);
        vec_t v;
        v.rst = r; v.we = we; v.wr = wr; v.wd = wd; v.iv = iv; v.ir = ir;
        v.r1 = r1; v.r2 = r2; v.e1 = e1; v.e2 = e2; v.eb1 = eb1; v.eb2 = eb2;
        tbl.push_back(v);
    endtask

    // Inputs change only on the falling edge so they are stable around posedge.
    task automatic applyStimulus(input logic r, input logic we, input logic [AW-1:0] wr,
                                 input logic [DW-1:0] wd, input logic iv, input logic [AW-1:0] ir,
                                 input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        @(negedge clk);
        rst = r; regWriteW = we; writeRegW = wr; resultW = wd;
        issueValidD = iv; issueRegD = ir; readReg1D = r1; readReg2D = r2;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] modelRead(input logic [AW-1:0] idx);
        if (idx == 0) return '0;
        if (regWriteW && writeRegW == idx) return resultW;
        return mRegs[idx];
    endfunction

    function automatic logic modelBusy(input logic [AW-1:0] idx);
        if (idx == 0) return 1'b0;
        if (regWriteW && writeRegW == idx) return 1'b0;
        return mBusy[idx];
    endfunction

    task automatic clockAndModel();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NR; i++) begin
                mRegs[i] = '0;
                mBusy[i] = 1'b0;
            end
        end else begin
            if (regWriteW && writeRegW != 0) mRegs[writeRegW] = resultW;
            if (regWriteW) mBusy[writeRegW] = 1'b0;
            if (issueValidD && issueRegD != 0) mBusy[issueRegD] = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1; regWriteW = 1'b0; writeRegW = '0; resultW = '0;
        issueValidD = 1'b0; issueRegD = '0; readReg1D = '0; readReg2D = '0;

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        clockAndModel();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        clockAndModel();

        for (int i = 0; i < NR; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, AW'(i), AW'(NR - 1 - i));
            checkOutput("resetRead1", readData1D, 32'h0);
            checkOutput("resetRead2", readData2D, 32'h0);
            checkOutput("resetBusy1", 32'(busy1D), 32'h0);
            checkOutput("resetBusy2", 32'(busy2D), 32'h0);
            clockAndModel();
        end

        //     rst we wr  wd            iv ir  r1  r2  e1            e2            b1 b2
        addVec(0,  1, 5,  32'hDEADBEEF, 0, 0,  5,  0,  32'hDEADBEEF, 32'h0,        0, 0);
        addVec(0,  1, 0,  32'h00001234, 0, 0,  5,  0,  32'hDEADBEEF, 32'h0,        0, 0);
        addVec(0,  0, 0,  32'h0,        0, 0,  0,  5,  32'h0,        32'hDEADBEEF, 0, 0);
        addVec(0,  1, 7,  32'hCAFEF00D, 0, 0,  6,  7,  32'h0,        32'hCAFEF00D, 0, 0);
        addVec(0,  0, 0,  32'h0,        1, 9,  9,  7,  32'h0,        32'hCAFEF00D, 0, 0);
        addVec(0,  0, 0,  32'h0,        0, 0,  9,  9,  32'h0,        32'h0,        1, 1);
        addVec(0,  1, 9,  32'h00000011, 0, 0,  9,  9,  32'h00000011, 32'h00000011, 0, 0);
        addVec(0,  0, 0,  32'h0,        0, 0,  9,  0,  32'h00000011, 32'h0,        0, 0);
        addVec(0,  1, 3,  32'h00000033, 1, 3,  3,  3,  32'h00000033, 32'h00000033, 0, 0);
        addVec(0,  0, 0,  32'h0,        0, 0,  3,  3,  32'h00000033, 32'h00000033, 1, 1);
        addVec(0,  1, 4,  32'h00000055, 0, 0,  4,  3,  32'h00000055, 32'h00000033, 0, 1);
        addVec(0,  0, 0,  32'h0,        1, 4,  4,  3,  32'h00000055, 32'h00000033, 0, 1);
        addVec(0,  0, 0,  32'h0,        0, 0,  4,  5,  32'h00000055, 32'hDEADBEEF, 1, 0);
        addVec(1,  1, 4,  32'h000000AA, 1, 2,  4,  4,  32'h000000AA, 32'h000000AA, 0, 0);
        addVec(0,  0, 0,  32'h0,        0, 0,  4,  3,  32'h0,        32'h0,        0, 0);
        addVec(0,  0, 0,  32'h0,        0, 0,  2,  5,  32'h0,        32'h0,        0, 0);

        foreach (tbl[k]) begin
            applyStimulus(tbl[k].rst, tbl[k].we, tbl[k].wr, tbl[k].wd,
                          tbl[k].iv, tbl[k].ir, tbl[k].r1, tbl[k].r2);
            checkOutput($sformatf("vec%0d.data1", k), readData1D, tbl[k].e1);
            checkOutput($sformatf("vec%0d.data2", k), readData2D, tbl[k].e2);
            checkOutput($sformatf("vec%0d.busy1", k), 32'(busy1D), 32'(tbl[k].eb1));
            checkOutput($sformatf("vec%0d.busy2", k), 32'(busy2D), 32'(tbl[k].eb2));
            clockAndModel();
        end

        // Issue then retire with a gap, watching the source stay blocked until writeback.
        applyStimulus(0, 0, 0, 0, 1, 12, 12, 0);
        clockAndModel();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 12);
            checkOutput("holdBusy2", 32'(busy2D), 32'h1);
            clockAndModel();
        end
        applyStimulus(0, 1, 12, 32'h0BADF00D, 0, 0, 12, 12);
        checkOutput("retireBusy2", 32'(busy2D), 32'h0);
        checkOutput("retireData1", readData1D, 32'h0BADF00D);
        clockAndModel();

        for (int n = 0; n < 600; n++) begin
            logic          r, we, iv;
            logic [AW-1:0] wr, ir, r1, r2;
            logic [DW-1:0] wd;
            r  = ($urandom_range(0, 59) == 0);
            we = $urandom_range(0, 1) == 1;
            iv = $urandom_range(0, 9) < 4;
            wr = AW'($urandom_range(0, NR - 1));
            ir = ($urandom_range(0, 5) == 0) ? wr : AW'($urandom_range(0, NR - 1));
            wd = $urandom;
            r1 = ($urandom_range(0, 3) == 0) ? wr : AW'($urandom_range(0, NR - 1));
            r2 = ($urandom_range(0, 3) == 0) ? r1 : AW'($urandom_range(0, NR - 1));
            applyStimulus(r, we, wr, wd, iv, ir, r1, r2);
            checkOutput("rndData1", readData1D, modelRead(readReg1D));
            checkOutput("rndData2", readData2D, modelRead(readReg2D));
            checkOutput("rndBusy1", 32'(busy1D), 32'(modelBusy(readReg1D)));
            checkOutput("rndBusy2", 32'(busy2D), 32'(modelBusy(readReg2D)));
            clockAndModel();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, register index width (2**ADDR_W registers).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 regWriteW  input  1  writeback write enable.
REQ-006 writeRegW  input  ADDR_W  writeback destination index.
REQ-007 resultW  input  DATA_W  writeback data.
REQ-008 readReg1D  input  ADDR_W  decode read index, port 1.
REQ-009 readReg2D  input  ADDR_W  decode read index, port 2.
REQ-010 readData1D  output  DATA_W  port 1 read data.
REQ-011 readData2D  output  DATA_W  port 2 read data.
REQ-012 issueValidD  input  1  instruction with register destination issued this cycle.
REQ-013 issueRegD  input  ADDR_W  destination index of issued instruction.
REQ-014 busy1D  output  1  port 1 source has a pending write.
REQ-015 busy2D  output  1  port 2 source has a pending write.

Function
REQ-016 Storage SHALL be 2**ADDR_W registers of DATA_W bits; register 0 SHALL always read 0 and SHALL never be written.
REQ-017 A write SHALL occur at the rising edge when regWriteW=1 and writeRegW!=0, storing resultW.
REQ-018 Read ports SHALL be combinational, zero-cycle latency, with no edge between index and data.
REQ-019 Write-through bypass: when regWriteW=1, writeRegW!=0 and writeRegW equals a read index, that port SHALL return resultW in the same cycle.
REQ-020 Both read ports SHALL resolve independently; identical indices on both ports SHALL return identical data.
REQ-021 Scoreboard: one busy bit per register; rising edge with issueValidD=1 and issueRegD!=0 SHALL set busy[issueRegD].
REQ-022 Rising edge with regWriteW=1 SHALL clear busy[writeRegW].
REQ-023 Simultaneous set and clear of the same index SHALL leave the bit set (newer issue wins).
REQ-024 Simultaneous set and clear of different indices SHALL both take effect.
REQ-025 busy[0] SHALL be constant 0.
REQ-026 busyND SHALL equal busy[readRegND] AND NOT (regWriteW AND writeRegW==readRegND), i.e. a clear in flight this cycle SHALL unblock the reader.
REQ-027 A write to a non-busy register SHALL be accepted and SHALL leave its busy bit 0.

Reset
REQ-028 rst=1 at a rising edge SHALL clear every register to 0 and every busy bit to 0.
REQ-029 rst SHALL take priority over a simultaneous write or issue in the same cycle.
REQ-030 During rst=1, readData1D/readData2D SHALL still reflect the array plus bypass (REQ-019); busy outputs SHALL be 0 from the first cycle after the reset edge.

Structure
REQ-031 DATA_W and ADDR_W defaults, and the zero-register index constant, SHALL live in the shared processor package.
REQ-032 The scoreboard SHALL be a sub-module named reg_scoreboard (busy vector, set/clear logic, busy lookups); the data array and bypass stay in register_file.

Verification
REQ-033 Reset, then read all 32 indices on both ports -> every readData = 0x00000000, busy1D=busy2D=0.
REQ-034 Write r5=0xDEADBEEF; next cycle read r5 on port 1 -> 0xDEADBEEF; write r0=0x1234 -> r0 reads 0.
REQ-035 Same cycle regWriteW=1, writeRegW=7, resultW=0xCAFEF00D, readReg2D=7 -> readData2D=0xCAFEF00D in that cycle.
REQ-036 Issue r9; next cycle readReg1D=9 -> busy1D=1; writeback r9 -> busy1D=0 in the writeback cycle and after.
REQ-037 Same edge issue r3 and writeback r3 -> busy for r3 remains 1 afterward.
REQ-038 Write r4=0x55, issue r4, then assert rst with regWriteW=1 writeRegW=4 resultW=0xAA -> r4 reads 0 and busy r4=0 after the edge.
